// File: rtl/rv32i_fetch_pkg.sv
// Shared constants and state encoding for the RV32I instruction-fetch responder.
package rv32i_fetch_pkg;

  localparam int unsigned AW_DEFAULT = 10;
  localparam logic [31:0] RV_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_array.sv
// Single-port 2**AW x 32 instruction RAM; registered read that holds when not enabled.
module imem_array #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-fetch responder: owns the instruction memory, inserts post-redirect bubbles,
// holds on stall and accepts program download. Optional bounds check: IMEM_BOUNDS_CHECK_EN.
module imem_fetch_resp
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned AW            = AW_DEFAULT,
  parameter int unsigned FLUSH_BUBBLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  input  logic          stall,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic          instr_valid,
  output logic          misalign,
  output logic          oob_err
);

  localparam logic [1:0] BCNT_INIT = 2'(FLUSH_BUBBLES - 1);

  fetch_state_t  state;
  logic [1:0]    bcnt;
  logic          sel_mem;
  logic          fetch_slot;
  logic          pc_misal;
  logic          pc_oob;
  logic          good_fetch;
  logic [AW-1:0] mem_addr;
  logic [31:0]   rdata;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign pc_oob = |pc[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else if (fetch_slot && pc_oob) begin
      oob_err <= 1'b1;
    end
  end
`else
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[31:AW+2];
  assign pc_oob       = 1'b0;
  assign oob_err      = 1'b0;
`endif

  assign pc_misal = |pc[1:0];

  // A fetch happens in RUN when not stalled, or on the last bubble of FLUSH (stall ignored there).
  always_comb begin
    fetch_slot = 1'b0;
    if (!reset && !ld_en && !flush) begin
      case (state)
        RUN:     fetch_slot = !stall;
        FLUSH:   fetch_slot = (bcnt == 2'd0);
        default: fetch_slot = 1'b0;
      endcase
    end
  end

  assign good_fetch = fetch_slot && !pc_misal && !pc_oob;
  assign mem_addr   = ld_en ? ld_addr : pc[AW+1:2];

  imem_array #(
    .AW(AW)
  ) u_imem_array (
    .clk  (clk),
    .we   (ld_en),
    .re   (good_fetch),
    .addr (mem_addr),
    .wdata(ld_data),
    .rdata(rdata)
  );

  // The RAM output register doubles as the instr register; sel_mem masks it to NOP.
  assign instr = sel_mem ? rdata : RV_NOP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      bcnt        <= 2'd0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      sel_mem     <= 1'b0;
    end else if (ld_en) begin
      state       <= LOAD;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      sel_mem     <= 1'b0;
    end else if (flush) begin
      state       <= FLUSH;
      bcnt        <= BCNT_INIT;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      sel_mem     <= 1'b0;
    end else begin
      if (fetch_slot) begin
        instr_pc    <= pc;
        instr_valid <= good_fetch;
        sel_mem     <= good_fetch;
        misalign    <= pc_misal;
      end
      case (state)
        RUN: ;
        FLUSH: begin
          if (bcnt == 2'd0) begin
            state <= RUN;
          end else begin
            bcnt        <= bcnt - 2'd1;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            sel_mem     <= 1'b0;
          end
        end
        LOAD: begin
          state       <= RUN;
          instr_valid <= 1'b0;
          misalign    <= 1'b0;
          sel_mem     <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed, table-driven bench for imem_fetch_resp (AW=10, FLUSH_BUBBLES=2).
module tb_imem_fetch_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign;
  logic        oob_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  imem_fetch_resp #(
    .AW(10),
    .FLUSH_BUBBLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .stall      (stall),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .misalign   (misalign),
    .oob_err    (oob_err)
  );

  typedef struct {
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        c_pc;
    logic        e_valid;
    logic        e_mis;
    logic        e_oob;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic le, input logic [9:0] la, input logic [31:0] ld,
                              input logic [31:0] p, input logic st, input logic fl,
                              input logic [31:0] ei, input logic [31:0] ep, input logic cp,
                              input logic ev, input logic em, input logic eo);
    vec_t v;
    v.ld_en = le; v.ld_addr = la; v.ld_data = ld; v.pc = p; v.stall = st; v.flush = fl;
    v.e_instr = ei; v.e_pc = ep; v.c_pc = cp; v.e_valid = ev; v.e_mis = em; v.e_oob = eo;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic le, input logic [9:0] la,
                       input logic [31:0] ld, input logic [31:0] p, input logic st,
                       input logic fl);
    @(negedge clk);
    reset = rst; ld_en = le; ld_addr = la; ld_data = ld; pc = p; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic cp, input logic ev, input logic em, input logic eo);
    check({tag, ".instr"}, instr, ei);
    if (cp) check({tag, ".instr_pc"}, instr_pc, ep);
    check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
    check({tag, ".misalign"}, 32'(misalign), 32'(em));
    check({tag, ".oob_err"}, 32'(oob_err), 32'(eo));
  endtask

  initial begin
    logic oob_after;
    reset = 1'b1; pc = '0; stall = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Program download, then sequential fetch.
    add(1, 10'd0, 32'h00500093, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(1, 10'd1, 32'h00A00113, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(1, 10'd2, 32'h002081B3, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(1, 10'd3, 32'h00000063, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h0, 0, 0, 32'h00500093, 32'h0, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'h4, 0, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'h8, 0, 0, 32'h002081B3, 32'h8, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'hC, 0, 0, 32'h00000063, 32'hC, 1, 1, 0, 0);
    // Stall holds while pc moves on.
    add(0, 10'd0, 0, 32'h4, 0, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'h8, 1, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'hC, 1, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'hC, 1, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'hC, 0, 0, 32'h00000063, 32'hC, 1, 1, 0, 0);
    // Flush: two bubbles, then the pc sampled on the exit cycle.
    add(0, 10'd0, 0, 32'h8, 0, 0, 32'h002081B3, 32'h8, 1, 1, 0, 0);
    add(0, 10'd0, 0, 32'h8, 0, 1, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h0, 0, 0, 32'h00500093, 32'h0, 1, 1, 0, 0);
    // Second flush during bubbles reloads the count; stall inside FLUSH is ignored.
    add(0, 10'd0, 0, 32'h4, 0, 1, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h0, 0, 1, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h4, 1, 0, NOP, 0, 0, 0, 0, 0);
    add(0, 10'd0, 0, 32'h4, 0, 0, 32'h00A00113, 32'h4, 1, 1, 0, 0);
    // Misaligned fetch, then recovery.
    add(0, 10'd0, 0, 32'h6, 0, 0, NOP, 32'h6, 1, 0, 1, 0);
    add(0, 10'd0, 0, 32'h8, 0, 0, 32'h002081B3, 32'h8, 1, 1, 0, 0);
    // Out-of-range pc.
`ifdef IMEM_BOUNDS_CHECK_EN
    add(0, 10'd0, 0, 32'h1000, 0, 0, NOP, 32'h1000, 1, 0, 0, 1);
    oob_after = 1'b1;
`else
    add(0, 10'd0, 0, 32'h1000, 0, 0, 32'h00500093, 32'h1000, 1, 1, 0, 0);
    oob_after = 1'b0;
`endif
    add(0, 10'd0, 0, 32'h4, 0, 0, 32'h00A00113, 32'h4, 1, 1, 0, oob_after);
    add(0, 10'd0, 0, 32'hC, 0, 0, 32'h00000063, 32'hC, 1, 1, 0, oob_after);

    drive(1, 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    check_all("reset", NOP, 32'h0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].ld_en, vecs[i].ld_addr, vecs[i].ld_data, vecs[i].pc,
            vecs[i].stall, vecs[i].flush);
      check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].c_pc,
                vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_oob);
    end

    // Reset mid-FLUSH with a load word in flight: reset wins on outputs, write still lands.
    drive(0, 0, 0, 0, 32'h0, 0, 1);
    check_all("rst_seq.flush", NOP, 32'h0, 0, 0, 0, oob_after);
    drive(1, 1, 10'd5, 32'hDEADBEEF, 32'h0, 0, 0);
    check_all("rst_seq.reset", NOP, 32'h0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h14, 0, 0);
    check_all("rst_seq.fetch5", 32'hDEADBEEF, 32'h14, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_all("rst_seq.fetch0", 32'h00500093, 32'h0, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
